uart_param_core: RTL and testbench
==================================

// Module: uart_param_core
// PURPOSE
//  Parametrised full-duplex UART core: generic data width, baud divisor, optional parity, 1/2 stop bits.
//  TX side: valid/ready handshake. RX side: synchronised, mid-bit sampled, with parity/framing error flags.
//  Keeps the sticky halt-on-sentinel behaviour of the first-generation UART, now configurable.
//  Sits between the system bus and the pad-level tx/rx pins.
// PARAMETERS
//  DATA_W       8          data bits per frame (5..16)
//  CLKS_PER_BIT 16         clk cycles per bit (>=4, even)
//  PARITY_EN    0          1 = parity bit after data
//  PARITY_ODD   0          1 = odd parity, 0 = even (ignored if PARITY_EN=0)
//  STOP_BITS    1          1 or 2 stop bits (TX); RX checks the first stop bit only
//  HALT_CODE    {DATA_W{1}} TX word that triggers halt instead of being sent
// PORTS
//  clk           in   1       clock, all logic rising-edge
//  reset         in   1       synchronous, active-high
//  tx_data       in   DATA_W  word to transmit
//  tx_valid      in   1       tx_data valid
//  tx_ready      out  1       core can accept tx_data this cycle
//  tx            out  1       serial out, idle high
//  rx            in   1       serial in, asynchronous
//  rx_data       out  DATA_W  last received word, held until next frame
//  rx_valid      out  1       1-cycle pulse, rx_data/error flags valid
//  rx_parity_err out  1       parity mismatch, qualified by rx_valid
//  rx_frame_err  out  1       stop bit sampled 0, qualified by rx_valid
//  halt_status   out  1       sticky halt flag
//  halt_clear    in   1       clears halt_status
// BEHAVIOUR
//  Reset: tx=1, tx_ready=1, rx_data=0, rx_valid=0, both err=0, halt_status=0, FSMs IDLE, sync flops=1.
//  Reset mid-frame aborts both FSMs; tx=1 from the cycle after reset is sampled. No partial rx_valid.
//  TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; each bit held exactly CLKS_PER_BIT cycles.
//  - tx_ready = (state==IDLE) && !halt_status. Transfer on tx_valid && tx_ready.
//  - Data latched at transfer; tx goes low (start bit) the next cycle. LSB first.
//  - Parity = ^data XOR PARITY_ODD. STOP lasts STOP_BITS*CLKS_PER_BIT cycles; tx_ready returns the cycle after.
//  - Frame length = (1+DATA_W+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles, transfer to next tx_ready.
//  - Transferred word == HALT_CODE: not sent. tx stays 1; halt_status=1 next cycle; FSM stays IDLE.
//  - halt_status sticky until halt_clear=1 (cleared next cycle); tx_ready then returns.
//  - halt_clear while not halted: no effect. Halt never affects RX.
//  RX: rx through 2-flop synchroniser (2-cycle latency), rest uses the synced signal.
//  - IDLE: synced rx==0 -> START, counter reset.
//  - START: at CLKS_PER_BIT/2 resample. 1 = glitch, back to IDLE with no outputs. 0 = DATA.
//  - DATA: sample every CLKS_PER_BIT (bit centre), shift in LSB first, DATA_W samples.
//  - PARITY (if enabled): sample and compare to parity of received data.
//  - STOP: sample at centre. rx_data updates and rx_valid pulses that same cycle.
//  - rx_parity_err and rx_frame_err are driven with rx_valid, 0 otherwise.
//  - Frame error (stop=0): word still delivered; FSM waits for synced rx==1 before IDLE (break safe).
//  - Valid stop: IDLE immediately, so a back-to-back start bit is detected.
//  TX and RX fully independent; simultaneous activity allowed; no internal loopback.
// TESTING (CLKS_PER_BIT=4, DATA_W=8 unless noted)
//  1 Reset: hold reset 2 cycles -> tx=1, tx_ready=1, halt_status=0, rx_valid=0.
//  2 TX 8'hAA, 8N1: pulse tx_valid -> tx = 0,0,1,0,1,0,1,0,1,1, 4 cycles per bit; tx_ready low 40 cycles.
//  3 Halt: send 8'hFF -> tx stays 1, halt_status=1, tx_ready=0. Pulse halt_clear -> tx_ready=1, then 8'h55 sent normally.
//  4 RX 8'hCC, clean 8N1 frame -> exactly one rx_valid, rx_data=8'hCC, both err=0.
//  5 Errors: PARITY_EN=1, wrong parity bit -> rx_parity_err=1 with rx_valid. Stop bit=0 -> rx_frame_err=1, no new frame until rx high.
//  6 Robustness: rx low 1 cycle -> no rx_valid. Assert reset mid TX frame -> tx=1 next cycle, tx_ready=1.

Source files
------------

// File: rtl/uart_param_core_if.sv
// Bus-side bundle for uart_param_core: TX valid/ready handshake and
// the received-word outputs with their error qualifiers.
interface uart_param_core_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_parity_err;
    logic              rx_frame_err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        input  rx_parity_err,
        input  rx_frame_err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid,
        output rx_parity_err,
        output rx_frame_err
    );
endinterface

// File: rtl/uart_param_core.sv
// Parametrised full-duplex UART: handshake TX with sticky halt word,
// synchronised mid-bit sampled RX with parity/framing flags.
module uart_param_core #(
    parameter int                DATA_W       = 8,
    parameter int                CLKS_PER_BIT = 16,
    parameter int                PARITY_EN    = 0,
    parameter int                PARITY_ODD   = 0,
    parameter int                STOP_BITS    = 1,
    parameter logic [DATA_W-1:0] HALT_CODE    = {DATA_W{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_param_core_if.slave     bus,
    output logic                 tx,
    input  logic                 rx,
    output logic                 halt_status,
    input  logic                 halt_clear
);

    localparam int TX_CNT_MAX = STOP_BITS * CLKS_PER_BIT;
    localparam int TCW        = $clog2(TX_CNT_MAX);
    localparam int RCW        = $clog2(CLKS_PER_BIT);
    localparam int BW         = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic ODD      = (PARITY_ODD != 0);
    localparam logic PEN      = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PAR,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP,
        RX_WAIT
    } rx_state_e;

    tx_state_e         tx_st_q;
    tx_state_e         tx_st_d;
    logic [TCW-1:0]    tx_cnt_q;
    logic [TCW-1:0]    tx_cnt_d;
    logic [BW-1:0]     tx_idx_q;
    logic [BW-1:0]     tx_idx_d;
    logic [DATA_W-1:0] tx_sh_q;
    logic [DATA_W-1:0] tx_sh_d;
    logic              tx_par_q;
    logic              tx_par_d;
    logic              halt_q;
    logic              halt_d;
    logic              tx_xfer;
    logic              tx_bit_end;
    logic              tx_stop_end;
    logic              tx_line;

    assign bus.tx_ready = (tx_st_q == TX_IDLE) && !halt_q;
    assign tx_xfer      = bus.tx_valid && bus.tx_ready;
    assign tx_bit_end   = (tx_cnt_q == TCW'(CLKS_PER_BIT - 1));
    assign tx_stop_end  = (tx_cnt_q == TCW'(TX_CNT_MAX - 1));
    assign halt_status  = halt_q;
    assign tx           = tx_line;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st_q  <= TX_IDLE;
            tx_cnt_q <= '0;
            tx_idx_q <= '0;
            tx_sh_q  <= '0;
            tx_par_q <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            tx_st_q  <= tx_st_d;
            tx_cnt_q <= tx_cnt_d;
            tx_idx_q <= tx_idx_d;
            tx_sh_q  <= tx_sh_d;
            tx_par_q <= tx_par_d;
            halt_q   <= halt_d;
        end
    end

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q + TCW'(1);
        tx_idx_d = tx_idx_q;
        tx_sh_d  = tx_sh_q;
        tx_par_d = tx_par_q;
        halt_d   = halt_q;
        if (halt_q && halt_clear) begin
            halt_d = 1'b0;
        end
        unique case (tx_st_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                // The halt word is swallowed: nothing leaves the pin.
                if (tx_xfer) begin
                    if (bus.tx_data == HALT_CODE) begin
                        halt_d = 1'b1;
                    end else begin
                        tx_st_d  = TX_START;
                        tx_sh_d  = bus.tx_data;
                        tx_par_d = (^bus.tx_data) ^ ODD;
                    end
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_st_d  = TX_DATA;
                    tx_cnt_d = '0;
                    tx_idx_d = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    tx_sh_d  = tx_sh_q >> 1;
                    if (tx_idx_q == BW'(DATA_W - 1)) begin
                        tx_st_d = PEN ? TX_PAR : TX_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + BW'(1);
                    end
                end
            end
            TX_PAR: begin
                if (tx_bit_end) begin
                    tx_st_d  = TX_STOP;
                    tx_cnt_d = '0;
                end
            end
            TX_STOP: begin
                if (tx_stop_end) begin
                    tx_st_d  = TX_IDLE;
                    tx_cnt_d = '0;
                end
            end
            default: begin
                tx_st_d  = TX_IDLE;
                tx_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        tx_line = 1'b1;
        unique case (tx_st_q)
            TX_START: tx_line = 1'b0;
            TX_DATA:  tx_line = tx_sh_q[0];
            TX_PAR:   tx_line = tx_par_q;
            default:  tx_line = 1'b1;
        endcase
    end

    rx_state_e         rx_st_q;
    rx_state_e         rx_st_d;
    logic              sync1_q;
    logic              sync2_q;
    logic [RCW-1:0]    rx_cnt_q;
    logic [RCW-1:0]    rx_cnt_d;
    logic [BW-1:0]     rx_idx_q;
    logic [BW-1:0]     rx_idx_d;
    logic [DATA_W-1:0] rx_sh_q;
    logic [DATA_W-1:0] rx_sh_d;
    logic              rx_pe_q;
    logic              rx_pe_d;
    logic [DATA_W-1:0] rx_data_q;
    logic [DATA_W-1:0] rx_data_d;
    logic              rx_valid_q;
    logic              rx_valid_d;
    logic              rx_perr_q;
    logic              rx_perr_d;
    logic              rx_ferr_q;
    logic              rx_ferr_d;
    logic              rxs;
    logic              rx_half;
    logic              rx_full;

    assign rxs               = sync2_q;
    assign rx_half           = (rx_cnt_q == RCW'(CLKS_PER_BIT / 2 - 1));
    assign rx_full           = (rx_cnt_q == RCW'(CLKS_PER_BIT - 1));
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_parity_err = rx_perr_q;
    assign bus.rx_frame_err  = rx_ferr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_sh_q    <= '0;
            rx_pe_q    <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_sh_q    <= rx_sh_d;
            rx_pe_q    <= rx_pe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q + RCW'(1);
        rx_idx_d   = rx_idx_q;
        rx_sh_d    = rx_sh_q;
        rx_pe_d    = rx_pe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_perr_d  = 1'b0;
        rx_ferr_d  = 1'b0;
        unique case (rx_st_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rxs) begin
                    rx_st_d = RX_START;
                    rx_pe_d = 1'b0;
                end
            end
            RX_START: begin
                // A start bit gone high by mid-bit was only a glitch.
                if (rx_half) begin
                    rx_cnt_d = '0;
                    rx_idx_d = '0;
                    rx_st_d  = rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_full) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rxs, rx_sh_q[DATA_W-1:1]};
                    if (rx_idx_q == BW'(DATA_W - 1)) begin
                        rx_st_d = PEN ? RX_PAR : RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + BW'(1);
                    end
                end
            end
            RX_PAR: begin
                if (rx_full) begin
                    rx_cnt_d = '0;
                    rx_pe_d  = rxs ^ (^rx_sh_q) ^ ODD;
                    rx_st_d  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_full) begin
                    rx_cnt_d   = '0;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    rx_perr_d  = rx_pe_q;
                    rx_ferr_d  = !rxs;
                    rx_st_d    = rxs ? RX_IDLE : RX_WAIT;
                end
            end
            RX_WAIT: begin
                // Held-low line (break): wait for idle before re-arming.
                rx_cnt_d = '0;
                if (rxs) begin
                    rx_st_d = RX_IDLE;
                end
            end
            default: begin
                rx_st_d  = RX_IDLE;
                rx_cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_param_core.sv
// Bench for uart_param_core: 8N1 instance and an 8O2 instance, checked
// against frame-level reference expectations built in the bench.
module tb_uart_param_core;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic rx_a;
    logic rx_b;
    logic tx_a;
    logic tx_b;
    logic halt_a;
    logic halt_b;
    logic hclr_a;
    logic hclr_b;

    uart_param_core_if #(.DATA_W(8)) ifa ();
    uart_param_core_if #(.DATA_W(8)) ifb ();

    uart_param_core #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ifa),
        .tx(tx_a), .rx(rx_a),
        .halt_status(halt_a), .halt_clear(hclr_a)
    );

    uart_param_core #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1),
        .PARITY_ODD(1), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ifb),
        .tx(tx_b), .rx(rx_b),
        .halt_status(halt_b), .halt_clear(hclr_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // {parity_err, frame_err, data}
    logic [9:0] got_a[$];
    logic [9:0] got_b[$];
    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];

    always @(negedge clk) begin
        if (ifa.rx_valid)
            got_a.push_back({ifa.rx_parity_err, ifa.rx_frame_err, ifa.rx_data});
        if (ifb.rx_valid)
            got_b.push_back({ifb.rx_parity_err, ifb.rx_frame_err, ifb.rx_data});
    end

    // Line level of bit slot j of a frame (start, LSB-first data, parity, stops).
    function automatic logic frame_bit(input logic [7:0] d, input int j,
                                       input bit pen, input bit odd);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        if (pen && j == 9) return (^d) ^ odd;
        return 1'b1;
    endfunction

    function automatic logic rdy(input int sel);
        return sel != 0 ? ifb.tx_ready : ifa.tx_ready;
    endfunction

    function automatic logic txl(input int sel);
        return sel != 0 ? tx_b : tx_a;
    endfunction

    task automatic tx_frame(input int sel, input logic [7:0] d);
        int nbits;
        bit pen;
        pen   = (sel != 0);
        nbits = pen ? 12 : 10;
        @(negedge clk);
        chk("tx_ready_pre", rdy(sel), 1);
        if (pen) begin ifb.tx_data = d; ifb.tx_valid = 1'b1; end
        else     begin ifa.tx_data = d; ifa.tx_valid = 1'b1; end
        for (int k = 0; k < nbits * CPB; k++) begin
            @(negedge clk);
            ifa.tx_valid = 1'b0;
            ifb.tx_valid = 1'b0;
            chk("tx_bit", txl(sel), frame_bit(d, k / CPB, pen, pen));
            chk("tx_ready_busy", rdy(sel), 0);
        end
        @(negedge clk);
        chk("tx_ready_post", rdy(sel), 1);
        chk("tx_idle", txl(sel), 1);
    endtask

    task automatic rx_drive(input int sel, input logic b, input int n);
        if (sel != 0) rx_b = b; else rx_a = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic rx_frame(input int sel, input logic [7:0] d,
                            input bit bad_par, input bit bad_stop,
                            input int gap);
        bit pen;
        pen = (sel != 0);
        if (pen) exp_b.push_back({bad_par, bad_stop, d});
        else     exp_a.push_back({1'b0, bad_stop, d});
        rx_drive(sel, 1'b0, CPB);
        for (int i = 0; i < 8; i++) rx_drive(sel, d[i], CPB);
        if (pen) rx_drive(sel, (^d) ^ 1'b1 ^ bad_par, CPB);
        rx_drive(sel, !bad_stop, CPB);
        if (bad_stop) rx_drive(sel, 1'b0, 3 * CPB);
        rx_drive(sel, 1'b1, gap);
    endtask

    task automatic rx_compare(input int sel);
        logic [9:0] g[$];
        logic [9:0] e[$];
        repeat (12) @(negedge clk);
        if (sel != 0) begin g = got_b; e = exp_b; got_b.delete(); exp_b.delete(); end
        else          begin g = got_a; e = exp_a; got_a.delete(); exp_a.delete(); end
        chk("rx_count", g.size(), e.size());
        for (int i = 0; i < e.size() && i < g.size(); i++) begin
            chk("rx_data", g[i][7:0], e[i][7:0]);
            chk("rx_ferr", g[i][8], e[i][8]);
            chk("rx_perr", g[i][9], e[i][9]);
        end
    endtask

    logic [7:0] d;

    initial begin
        reset = 1'b1;
        rx_a = 1'b1; rx_b = 1'b1;
        hclr_a = 1'b0; hclr_b = 1'b0;
        ifa.tx_data = '0; ifa.tx_valid = 1'b0;
        ifb.tx_data = '0; ifb.tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx", tx_a, 1);
        chk("rst_ready", ifa.tx_ready, 1);
        chk("rst_halt", halt_a, 0);
        chk("rst_rx_valid", ifa.rx_valid, 0);
        chk("rst_rx_data", ifa.rx_data, 0);
        chk("rst_errs", {ifa.rx_parity_err, ifa.rx_frame_err}, 0);
        chk("rst_tx_b", tx_b, 1);
        chk("rst_ready_b", ifb.tx_ready, 1);
        reset = 1'b0;

        tx_frame(0, 8'hAA);

        // halt_clear while not halted must be ignored
        hclr_a = 1'b1;
        @(negedge clk);
        hclr_a = 1'b0;
        chk("hclr_idle_halt", halt_a, 0);
        chk("hclr_idle_ready", ifa.tx_ready, 1);

        ifa.tx_data = 8'hFF; ifa.tx_valid = 1'b1;
        @(negedge clk);
        chk("halt_set", halt_a, 1);
        chk("halt_ready", ifa.tx_ready, 0);
        ifa.tx_data = 8'h12;
        repeat (6) @(negedge clk);
        chk("halt_tx_idle", tx_a, 1);
        chk("halt_sticky", halt_a, 1);
        ifa.tx_valid = 1'b0;
        hclr_a = 1'b1;
        @(negedge clk);
        hclr_a = 1'b0;
        chk("halt_clr", halt_a, 0);
        chk("halt_clr_ready", ifa.tx_ready, 1);
        tx_frame(0, 8'h55);

        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(0, 254));
            tx_frame(0, d);
            d = 8'($urandom_range(0, 254));
            tx_frame(1, d);
        end
        tx_frame(1, 8'h00);

        rx_frame(0, 8'hCC, 0, 0, 4);
        rx_compare(0);
        for (int i = 0; i < 5; i++)
            rx_frame(0, 8'($urandom), 0, 0, 0);
        rx_compare(0);
        for (int i = 0; i < 4; i++)
            rx_frame(1, 8'($urandom), 0, 0, 0);
        rx_frame(1, 8'($urandom), 1, 0, 2);
        rx_compare(1);

        rx_frame(0, 8'($urandom), 0, 1, 48);
        rx_frame(0, 8'h3A, 0, 0, 4);
        rx_compare(0);
        rx_frame(1, 8'($urandom), 0, 1, 48);
        rx_frame(1, 8'hC5, 0, 0, 4);
        rx_compare(1);

        rx_drive(0, 1'b0, 1);
        rx_drive(0, 1'b1, 40);
        rx_drive(1, 1'b0, 1);
        rx_drive(1, 1'b1, 40);
        rx_compare(0);
        rx_compare(1);

        // Abort a TX frame with reset
        ifa.tx_data = 8'h0F; ifa.tx_valid = 1'b1;
        @(negedge clk);
        ifa.tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy", ifa.tx_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", tx_a, 1);
        chk("mid_rst_ready", ifa.tx_ready, 1);
        reset = 1'b0;
        tx_frame(0, 8'h81);
        rx_compare(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
